// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: host command/config and capture/trigger handshake bundle
interface capture_sequencer_if #(parameter int W = 32);
  logic start, stop, ack, cfg_trig_en, cfg_full_speed, sample_valid, trig_hit, capture_done;
  logic [W-1:0] cfg_depth, cfg_trig_pos;
  logic sample_en, trig_en, full_speed, busy, triggered, done, err_cfg;
  logic [W-1:0] sample_depth, sample_last_cnt, trig_set_pos, trig_set_pos_minus1, after_trig_depth, sample_real_start;
  logic [2:0] state;
  modport master(
    output start, stop, ack, cfg_trig_en, cfg_full_speed, sample_valid, trig_hit, capture_done, cfg_depth, cfg_trig_pos,
    input sample_en, trig_en, full_speed, busy, triggered, done, err_cfg, sample_depth, sample_last_cnt, trig_set_pos,
    input trig_set_pos_minus1, after_trig_depth, sample_real_start, state
  );
  modport slave(
    input start, stop, ack, cfg_trig_en, cfg_full_speed, sample_valid, trig_hit, capture_done, cfg_depth, cfg_trig_pos,
    output sample_en, trig_en, full_speed, busy, triggered, done, err_cfg, sample_depth, sample_last_cnt, trig_set_pos,
    output trig_set_pos_minus1, after_trig_depth, sample_real_start, state
  );
endinterface

// File: rtl/capture_sequencer.sv
// capture_sequencer: latches run config, derives depth/trigger arithmetic and sequences sample_en/trig_en
module capture_sequencer #(
  parameter int PRE_W = 32,
  parameter int MIN_DEPTH = 1
) (
  input logic core_clk,
  input logic core_rst,
  capture_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, FILL = 3'd2, RUN = 3'd3, DONE = 3'd4} state_t;
  state_t state_q, state_d;
  logic [PRE_W-1:0] depth_q, depth_d, last_q, last_d, pos_q, pos_d, pos_m1_q, pos_m1_d;
  logic [PRE_W-1:0] after_q, after_d, real_q, real_d, cnt_q, cnt_d, last_c, pos_c, cnt_inc;
  logic sample_en_q, sample_en_d, trig_en_q, trig_en_d, full_speed_q, full_speed_d, busy_q, busy_d;
  logic triggered_q, triggered_d, done_q, done_d, err_q, err_d, trig_mode_q, trig_mode_d, fill_c;
  assign last_c = bus.cfg_depth - PRE_W'(1);
  assign pos_c = bus.cfg_trig_pos < last_c ? bus.cfg_trig_pos : last_c;
  assign fill_c = bus.cfg_trig_en && pos_c != '0;
  assign cnt_inc = cnt_q + PRE_W'(1);
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    last_d = last_q;
    pos_d = pos_q;
    pos_m1_d = pos_m1_q;
    after_d = after_q;
    real_d = real_q;
    cnt_d = cnt_q;
    sample_en_d = sample_en_q;
    trig_en_d = trig_en_q;
    full_speed_d = full_speed_q;
    triggered_d = triggered_q;
    done_d = done_q;
    err_d = err_q;
    trig_mode_d = trig_mode_q;
    case (state_q)
      IDLE: if (bus.start) begin
        err_d = bus.cfg_depth < PRE_W'(MIN_DEPTH);
        state_d = err_d ? IDLE : LOAD;
      end
      LOAD: begin
        depth_d = bus.cfg_depth;
        last_d = last_c;
        pos_d = pos_c;
        pos_m1_d = pos_c == '0 ? '0 : pos_c - PRE_W'(1);
        after_d = last_c - pos_c;
        real_d = pos_c == '0 ? '0 : bus.cfg_depth - pos_c;
        trig_mode_d = bus.cfg_trig_en;
        full_speed_d = bus.cfg_full_speed;
        triggered_d = 1'b0;
        cnt_d = '0;
        sample_en_d = 1'b1;
        state_d = fill_c ? FILL : RUN;
        trig_en_d = fill_c ? 1'b0 : bus.cfg_trig_en;
      end
      FILL: if (bus.sample_valid) begin
        cnt_d = cnt_inc;
        state_d = cnt_inc == pos_q ? RUN : FILL;
        trig_en_d = cnt_inc == pos_q ? trig_mode_q : 1'b0;
      end
      RUN: begin
        triggered_d = triggered_q | bus.trig_hit;
        if (bus.capture_done) begin
          sample_en_d = 1'b0;
          trig_en_d = 1'b0;
          done_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (bus.ack) begin
        done_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.stop && (state_q == LOAD || state_q == FILL || state_q == RUN)) begin
      state_d = IDLE;
      sample_en_d = 1'b0;
      trig_en_d = 1'b0;
      done_d = 1'b0;
    end
    busy_d = state_d != IDLE && state_d != DONE;
  end
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q <= IDLE;
      depth_q <= '0;
      last_q <= '0;
      pos_q <= '0;
      pos_m1_q <= '0;
      after_q <= '0;
      real_q <= '0;
      cnt_q <= '0;
      sample_en_q <= 1'b0;
      trig_en_q <= 1'b0;
      full_speed_q <= 1'b0;
      busy_q <= 1'b0;
      triggered_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      trig_mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      last_q <= last_d;
      pos_q <= pos_d;
      pos_m1_q <= pos_m1_d;
      after_q <= after_d;
      real_q <= real_d;
      cnt_q <= cnt_d;
      sample_en_q <= sample_en_d;
      trig_en_q <= trig_en_d;
      full_speed_q <= full_speed_d;
      busy_q <= busy_d;
      triggered_q <= triggered_d;
      done_q <= done_d;
      err_q <= err_d;
      trig_mode_q <= trig_mode_d;
    end
  end
  assign bus.state = state_q;
  assign bus.sample_en = sample_en_q;
  assign bus.trig_en = trig_en_q;
  assign bus.full_speed = full_speed_q;
  assign bus.busy = busy_q;
  assign bus.triggered = triggered_q;
  assign bus.done = done_q;
  assign bus.err_cfg = err_q;
  assign bus.sample_depth = depth_q;
  assign bus.sample_last_cnt = last_q;
  assign bus.trig_set_pos = pos_q;
  assign bus.trig_set_pos_minus1 = pos_m1_q;
  assign bus.after_trig_depth = after_q;
  assign bus.sample_real_start = real_q;
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: table-driven config vectors plus directed multi-cycle sequences
module tb_capture_sequencer;
  logic core_clk = 1'b0, core_rst = 1'b1;
  int n_vec = 0, n_bad = 0;
  capture_sequencer_if #(.W(32)) bus();
  capture_sequencer #(.PRE_W(32), .MIN_DEPTH(1)) dut (.core_clk(core_clk), .core_rst(core_rst), .bus(bus));
  always #5 core_clk = ~core_clk;
  typedef struct {
    logic [31:0] depth, pos;
    logic ten;
    logic [31:0] last, set, m1, after, rs;
    logic [2:0] st;
  } vec_t;
  vec_t v[6];
  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic cfg(input logic [31:0] d, input logic [31:0] p, input logic te, input logic fs);
    bus.cfg_depth = d;
    bus.cfg_trig_pos = p;
    bus.cfg_trig_en = te;
    bus.cfg_full_speed = fs;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    v[0] = '{32'd1000, 32'd200, 1'b1, 32'd999, 32'd200, 32'd199, 32'd799, 32'd800, 3'd2};
    v[1] = '{32'd1000, 32'd5000, 1'b1, 32'd999, 32'd999, 32'd998, 32'd0, 32'd1, 3'd2};
    v[2] = '{32'd1000, 32'd0, 1'b1, 32'd999, 32'd0, 32'd0, 32'd999, 32'd0, 3'd3};
    v[3] = '{32'd16, 32'd3, 1'b0, 32'd15, 32'd3, 32'd2, 32'd12, 32'd13, 3'd3};
    v[4] = '{32'd1, 32'd0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd3};
    v[5] = '{32'hFFFF_FFFF, 32'd10, 1'b1, 32'hFFFF_FFFE, 32'd10, 32'd9, 32'hFFFF_FFF4, 32'hFFFF_FFF5, 3'd2};
    {bus.start, bus.stop, bus.ack, bus.sample_valid, bus.trig_hit, bus.capture_done} = '0;
    cfg(32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst state", 32'(bus.state), 32'd0);
    chk("rst outs", {25'd0, bus.sample_en, bus.trig_en, bus.full_speed, bus.busy, bus.triggered, bus.done, bus.err_cfg}, 32'd0);
    chk("rst depth", bus.sample_depth, 32'd0);
    chk("rst last", bus.sample_last_cnt, 32'd0);
    core_rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      cfg(v[i].depth, v[i].pos, v[i].ten, 1'b0);
      pulse_start();
      chk($sformatf("v%0d load state", i), 32'(bus.state), 32'd1);
      chk($sformatf("v%0d load sample_en", i), 32'(bus.sample_en), 32'd0);
      tick();
      chk($sformatf("v%0d state", i), 32'(bus.state), 32'(v[i].st));
      chk($sformatf("v%0d sample_en", i), 32'(bus.sample_en), 32'd1);
      chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'd1);
      chk($sformatf("v%0d trig_en", i), 32'(bus.trig_en), v[i].st == 3'd3 ? 32'(v[i].ten) : 32'd0);
      chk($sformatf("v%0d depth", i), bus.sample_depth, v[i].depth);
      chk($sformatf("v%0d last", i), bus.sample_last_cnt, v[i].last);
      chk($sformatf("v%0d set_pos", i), bus.trig_set_pos, v[i].set);
      chk($sformatf("v%0d minus1", i), bus.trig_set_pos_minus1, v[i].m1);
      chk($sformatf("v%0d after", i), bus.after_trig_depth, v[i].after);
      chk($sformatf("v%0d real_start", i), bus.sample_real_start, v[i].rs);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      chk($sformatf("v%0d stop state", i), 32'(bus.state), 32'd0);
      chk($sformatf("v%0d stop outs", i), {bus.sample_en, bus.trig_en, bus.busy, bus.done}, 32'd0);
      chk($sformatf("v%0d hold after", i), bus.after_trig_depth, v[i].after);
    end
    cfg(32'd1000, 32'd200, 1'b1, 1'b1);
    bus.sample_valid = 1'b1;
    pulse_start();
    tick();
    chk("A fill state", 32'(bus.state), 32'd2);
    for (int i = 0; i < 199; i++) tick();
    chk("A 199 valids state", 32'(bus.state), 32'd2);
    chk("A 199 valids trig_en", 32'(bus.trig_en), 32'd0);
    tick();
    chk("A 200 valids state", 32'(bus.state), 32'd3);
    chk("A 200 valids trig_en", 32'(bus.trig_en), 32'd1);
    chk("A full_speed", 32'(bus.full_speed), 32'd1);
    bus.trig_hit = 1'b1;
    tick();
    bus.trig_hit = 1'b0;
    chk("A triggered", 32'(bus.triggered), 32'd1);
    bus.capture_done = 1'b1;
    tick();
    bus.capture_done = 1'b0;
    chk("A done state", 32'(bus.state), 32'd4);
    chk("A done outs", {bus.sample_en, bus.trig_en, bus.busy, bus.done}, 32'd1);
    pulse_start();
    chk("A start in done", 32'(bus.state), 32'd4);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("A ack state", 32'(bus.state), 32'd0);
    chk("A ack done", 32'(bus.done), 32'd0);
    chk("A held after", bus.after_trig_depth, 32'd799);
    bus.sample_valid = 1'b0;
    cfg(32'd16, 32'd3, 1'b0, 1'b0);
    pulse_start();
    tick();
    chk("B run state", 32'(bus.state), 32'd3);
    chk("B trig_en", 32'(bus.trig_en), 32'd0);
    chk("B triggered cleared", 32'(bus.triggered), 32'd0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("B ack in run", 32'(bus.state), 32'd3);
    bus.cfg_depth = 32'd50;
    pulse_start();
    chk("B start in run state", 32'(bus.state), 32'd3);
    chk("B start in run depth", bus.sample_depth, 32'd16);
    bus.cfg_depth = 32'd16;
    bus.capture_done = 1'b1;
    tick();
    bus.capture_done = 1'b0;
    chk("B done", {bus.state, bus.done, bus.sample_en}, {3'd4, 1'b1, 1'b0});
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("B idle", {bus.state, bus.done}, {3'd0, 1'b0});
    bus.capture_done = 1'b1;
    tick();
    bus.capture_done = 1'b0;
    chk("B capture_done in idle", {bus.state, bus.done}, {3'd0, 1'b0});
    pulse_start();
    tick();
    chk("D run", 32'(bus.state), 32'd3);
    bus.stop = 1'b1;
    bus.capture_done = 1'b1;
    tick();
    {bus.stop, bus.capture_done} = 2'b00;
    chk("D stop beats done", {bus.state, bus.done, bus.sample_en, bus.busy}, {3'd0, 3'd0});
    cfg(32'd0, 32'd0, 1'b1, 1'b0);
    pulse_start();
    chk("C err_cfg", 32'(bus.err_cfg), 32'd1);
    chk("C state", 32'(bus.state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("C no sample_en", {bus.sample_en, bus.state}, 32'd0);
    end
    cfg(32'd16, 32'd0, 1'b0, 1'b1);
    pulse_start();
    chk("C err cleared", {bus.err_cfg, bus.state}, {1'b0, 3'd1});
    tick();
    chk("C run", {bus.state, bus.sample_en, bus.full_speed}, {3'd3, 1'b1, 1'b1});
    core_rst = 1'b1;
    tick();
    core_rst = 1'b0;
    chk("C rst state", 32'(bus.state), 32'd0);
    chk("C rst outs", {bus.sample_en, bus.trig_en, bus.full_speed, bus.busy, bus.triggered, bus.done, bus.err_cfg}, 32'd0);
    chk("C rst depth", bus.sample_depth, 32'd0);
    chk("C rst last", bus.sample_last_cnt, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Run controller for the capture datapath. Latches host acquisition settings and derives the per-run depth/trigger arithmetic (last count, trigger position, pre-trigger start, post-trigger depth). Sequences sample_en and trig_en through pre-trigger fill, trigger wait and completion, and reports status to the host register file. Sits between the host command/config registers and the capture and trigger blocks, all on core_clk.

Parameters:
PRE_W, 32, width of the pre-trigger fill counter and of all depth/position fields
MIN_DEPTH, 1, smallest legal cfg_depth; anything smaller raises err_cfg

Ports:
core_clk  in  1  core clock
core_rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle run request from host
stop  in  1  one-cycle abort request from host
ack  in  1  host acknowledge; clears done and returns the block to IDLE
cfg_depth  in  32  total samples per run
cfg_trig_pos  in  32  number of pre-trigger samples requested
cfg_trig_en  in  1  1 = triggered run, 0 = immediate run
cfg_full_speed  in  1  full-speed sampling mode, passed through
sample_valid  in  1  sample strobe from the sampler
trig_hit  in  1  trigger match from the trigger block
capture_done  in  1  one-cycle completion pulse from the capture block
sample_en  out  1  capture enable
trig_en  out  1  trigger arm to the capture and trigger blocks
full_speed  out  1  registered copy of cfg_full_speed
sample_depth  out  32  latched depth
sample_last_cnt  out  32  depth-1
trig_set_pos  out  32  clamped trigger position
trig_set_pos_minus1  out  32  trig_set_pos-1, saturating at 0
after_trig_depth  out  32  depth-1-trig_set_pos
sample_real_start  out  32  0 if trig_set_pos==0, else depth-trig_set_pos
busy  out  1  state is not IDLE and not DONE
triggered  out  1  trigger seen during RUN
done  out  1  run completed, held until ack
err_cfg  out  1  last start was rejected
state  out  3  IDLE=0, LOAD=1, FILL=2, RUN=3, DONE=4

Behaviour:
- Reset: state=IDLE; all outputs 0; internal fill counter 0.
- IDLE:
  - start with cfg_depth>=MIN_DEPTH: clear err_cfg, go to LOAD.
  - start with cfg_depth<MIN_DEPTH: set err_cfg, stay in IDLE.
- LOAD (one cycle):
  - Latch all cfg_* inputs.
  - trig_set_pos = min(cfg_trig_pos, cfg_depth-1).
  - Register all derived outputs; all subtractions are 32-bit unsigned.
  - Clear triggered and the fill counter. Go to FILL.
- FILL:
  - sample_en=1, trig_en=0.
  - Fill counter increments on each sample_valid.
  - Exit to RUN in the same cycle the count reaches trig_set_pos; exit immediately if trig_set_pos==0.
  - If cfg_trig_en==0, skip FILL and go straight to RUN.
- RUN:
  - sample_en=1, trig_en=latched cfg_trig_en.
  - trig_hit sets triggered (sticky).
  - capture_done: drop sample_en and trig_en on the next edge, set done, go to DONE.
- DONE:
  - sample_en=0, trig_en=0, done=1.
  - ack clears done and returns to IDLE.
  - start without ack is ignored.
- Latency:
  - start in cycle N: LOAD in N+1, sample_en high from N+2.
  - capture_done in cycle M: sample_en low and done high from M+1.
- stop in LOAD, FILL or RUN: go to IDLE next edge; sample_en, trig_en and busy go 0; done stays 0.
- stop and capture_done in the same cycle: stop wins (IDLE, done=0).
- start while busy or in DONE: ignored.
- ack outside DONE: ignored.
- capture_done outside RUN: ignored.
- Derived config outputs hold their values until the next LOAD, so readout logic can use them after DONE.
- core_rst asserted mid-run: full reset at the next edge; no partial state survives.

Test Plan:
- depth=1000, trig_pos=200, trig_en=1, continuous sample_valid, start -> LOAD outputs last_cnt=999, set_pos=200, minus1=199, after=799, real_start=800; sample_en at start+2; trig_en rises after 200 valids; trig_hit then capture_done -> done=1, triggered=1, sample_en=0 one cycle later.
- trig_en=0, depth=16, start -> FILL skipped, RUN reached at start+2 with trig_en=0; capture_done -> DONE; ack -> IDLE, done=0.
- trig_pos=5000, depth=1000 -> set_pos clamped to 999, after_trig_depth=0, real_start=1.
- trig_pos=0 -> minus1=0, real_start=0, FILL exits immediately; depth=0 start -> err_cfg=1, state stays IDLE, sample_en never asserts.
- stop asserted during FILL, and separately stop coincident with capture_done in RUN -> IDLE next edge, done=0, sample_en=0.
- core_rst asserted during RUN -> all outputs 0 next edge; second start during RUN ignored (state, counters unchanged).
